// File: rtl/branch_resolve_predictor.sv
// branch_resolve_predictor
//
// Consumer end of the branch comparator. Selects the comparator sign mode,
// turns the less/equal flags into a resolved direction for EX, detects
// mispredictions, and trains a direct-mapped table. Each table entry holds a
// valid bit, a tag, a branch target and a 2-bit saturating counter. The same
// table gives IF a 0-cycle next-PC prediction.
//
// Optional feature macro: BP_STATS_EN (adds o_br_cnt / o_mispred_cnt).
//
// Ports:
//   i_clk, i_rst_n        clock; asynchronous active-low reset
//   i_if_pc               fetch PC to predict
//   o_pred_taken          IF prediction: redirect fetch to o_pred_target
//   o_pred_target         predicted next PC (table target, else i_if_pc+4)
//   i_ex_valid            EX holds a valid, non-flushed instruction
//   i_ex_is_br/_is_jal    EX instruction class
//   i_ex_funct3           branch funct3
//   i_ex_pc, i_ex_target  EX PC and computed target
//   i_ex_pred_taken/_pred_target   prediction carried down from IF
//   o_br_un               comparator select: 0 = unsigned, 1 = signed
//   i_br_less, i_br_equal comparator results
//   o_ex_taken            resolved direction
//   o_mispredict          flush request; fetch resumes at o_redirect_pc
//   o_redirect_pc         correct next PC (valid whenever o_mispredict=1)
//   o_br_cnt, o_mispred_cnt  (BP_STATS_EN only) saturating event counters
//
// There is no handshake on any port: every input is sampled each cycle and
// every output is combinational or a direct register view.

module branch_resolve_predictor #(
  parameter int INDEX_W = 6,
  localparam int TAG_W  = 30 - INDEX_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jal,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_ex_taken,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
`endif
);

  localparam int ENTRIES = 2 ** INDEX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  // ---------------------------------------------------------------------------
  // IF-side prediction (reads pre-write table contents; no bypass from EX)
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;

  assign if_idx = i_if_pc[INDEX_W+1:2];
  assign if_tag = i_if_pc[31:INDEX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign o_pred_taken  = if_hit & ctr_q[if_idx][1];
  assign o_pred_target = o_pred_taken ? tgt_q[if_idx] : (i_if_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // EX-side resolution
  // ---------------------------------------------------------------------------
  logic dir;
  logic f3_valid;
  logic ctrl_ok;
  logic upd;

  // Only BLTU/BGEU compare unsigned.
  assign o_br_un = ~(i_ex_funct3 == 3'b110 || i_ex_funct3 == 3'b111);

  always_comb begin
    dir      = 1'b0;
    f3_valid = 1'b1;
    case (i_ex_funct3)
      3'b000:          dir = i_br_equal;
      3'b001:          dir = ~i_br_equal;
      3'b100, 3'b110:  dir = i_br_less;
      3'b101, 3'b111:  dir = ~i_br_less;
      default: begin
        // 010/011 are not branch encodings: never taken, never classified.
        dir      = 1'b0;
        f3_valid = 1'b0;
      end
    endcase
  end

  // JAL is classified regardless of whatever sits in the funct3 field.
  assign ctrl_ok = i_ex_is_jal | (i_ex_is_br & f3_valid);
  assign upd     = i_ex_valid & ctrl_ok;

  assign o_ex_taken    = i_ex_valid & (i_ex_is_jal | (i_ex_is_br & dir));
  assign o_mispredict  = upd & ((o_ex_taken != i_ex_pred_taken) |
                                (o_ex_taken & (i_ex_pred_target != i_ex_target)));
  assign o_redirect_pc = o_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Table training
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  logic               ex_hit;
  logic [1:0]         ctr_step;

  assign ex_idx = i_ex_pc[INDEX_W+1:2];
  assign ex_tag = i_ex_pc[31:INDEX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    ctr_step = ctr_q[ex_idx];
    if (o_ex_taken) begin
      if (ctr_q[ex_idx] != 2'b11) ctr_step = ctr_q[ex_idx] + 2'b01;
    end else begin
      if (ctr_q[ex_idx] != 2'b00) ctr_step = ctr_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= i_ex_is_jal ? 2'b11 : ctr_step;
        if (o_ex_taken) tgt_q[ex_idx] <= i_ex_target;
      end else if (o_ex_taken) begin
        // Allocate only on a taken miss; not-taken misses leave the entry alone.
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= i_ex_target;
        ctr_q[ex_idx]   <= i_ex_is_jal ? 2'b11 : 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd && br_cnt_q != 32'hFFFF_FFFF)           br_cnt_d  = br_cnt_q + 32'd1;
    if (o_mispredict && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;
`endif

endmodule
